// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared opcode constants and ALU select encoding for decode_execute_unit
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alusel_e;

    // Map funct3 plus the funct7[5] "alternate" bit to an ALU operation.
    // The caller decides whether alt is meaningful (SUB only exists for R-type).
    function automatic alusel_e f3_to_alusel(input logic [2:0] funct3, input logic alt);
        alusel_e sel;
        case (funct3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            3'b111:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// rtl/rv_alu.sv - combinational 32-bit ALU driven by a 3-bit operation select
module rv_alu
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  alusel_e         i_alusel,
    output logic [XLEN-1:0] o_result
);

    logic [4:0] w_shamt;

    assign w_shamt = i_op2[4:0];

    // Select the operation; all arithmetic wraps modulo 2^32.
    always_comb begin
        o_result = '0;
        case (i_alusel)
            ALU_ADD: o_result = i_op1 + i_op2;
            ALU_SUB: o_result = i_op1 - i_op2;
            ALU_AND: o_result = i_op1 & i_op2;
            ALU_OR:  o_result = i_op1 | i_op2;
            ALU_XOR: o_result = i_op1 ^ i_op2;
            ALU_SLL: o_result = i_op1 << w_shamt;
            ALU_SRL: o_result = i_op1 >> w_shamt;
            ALU_SRA: o_result = $unsigned($signed(i_op1) >>> w_shamt);
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/decode_execute_unit.sv
// rtl/decode_execute_unit.sv - RV32I-subset decoder, control and ALU with registered EX/MEM outputs
module decode_execute_unit
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            out_valid,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_link,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch_taken,
    output logic            out_jump,
    output logic            out_illegal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic            w_f3_alu_ok;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    alusel_e         w_alusel;
    logic            w_legal;
    logic            w_wb;
    logic            w_mr;
    logic            w_mw;
    logic            w_br;
    logic            w_jal;
    logic            w_accept;
    logic [XLEN-1:0] w_alu_result;

    logic            r_valid;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_store_data;
    logic [XLEN-1:0] r_link;
    logic            r_reg_write;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_branch_taken;
    logic            r_jump;
    logic            r_illegal;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_funct7 = inst[31:25];
    assign w_rd     = inst[11:7];
    assign rs1_addr = inst[19:15];
    assign rs2_addr = inst[24:20];

    assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
    assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // funct3 010/011 is an illegal encoding for ALU ops
    assign w_f3_alu_ok = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);

    // Decode opcode into operand selection, ALU op, control intents and legality
    always_comb begin
        w_legal  = 1'b0;
        w_op1    = rs1_data;
        w_op2    = rs2_data;
        w_alusel = ALU_ADD;
        w_wb     = 1'b0;
        w_mr     = 1'b0;
        w_mw     = 1'b0;
        w_br     = 1'b0;
        w_jal    = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_legal  = w_f3_alu_ok &&
                           ((w_funct7 == 7'b0000000) ||
                            ((w_funct7 == 7'b0100000) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
                w_alusel = f3_to_alusel(w_funct3, w_funct7[5]);
                w_wb     = 1'b1;
            end
            OP_I: begin
                w_legal  = w_f3_alu_ok;
                w_op2    = w_imm_i;
                // Only SRAI uses funct7[5]; ADDI with a negative immediate must stay ADD
                w_alusel = f3_to_alusel(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                w_wb     = 1'b1;
            end
            OP_LOAD: begin
                w_legal = (w_funct3 == 3'b010);
                w_op2   = w_imm_i;
                w_wb    = 1'b1;
                w_mr    = 1'b1;
            end
            OP_STORE: begin
                w_legal = (w_funct3 == 3'b010);
                w_op2   = w_imm_s;
                w_mw    = 1'b1;
            end
            OP_BRANCH: begin
                w_legal = (w_funct3 == 3'b000);
                w_op1   = pc;
                w_op2   = w_imm_b;
                w_br    = 1'b1;
            end
            OP_JAL: begin
                w_legal = 1'b1;
                w_op1   = pc;
                w_op2   = w_imm_j;
                w_wb    = 1'b1;
                w_jal   = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_legal;

    rv_alu u_alu (
        .i_op1    (w_op1),
        .i_op2    (w_op2),
        .i_alusel (w_alusel),
        .o_result (w_alu_result)
    );

    // EX/MEM register stage; enables are gated by valid and legality, data is captured freely
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_rd           <= '0;
            r_result       <= '0;
            r_store_data   <= '0;
            r_link         <= '0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_jump         <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_valid        <= in_valid;
            r_rd           <= w_rd;
            r_result       <= w_alu_result;
            r_store_data   <= rs2_data;
            r_link         <= pc + 32'd4;
            r_reg_write    <= w_accept && w_wb && (w_rd != 5'd0);
            r_mem_read     <= w_accept && w_mr;
            r_mem_write    <= w_accept && w_mw;
            r_branch_taken <= w_accept && w_br && (rs1_data == rs2_data);
            r_jump         <= w_accept && w_jal;
            r_illegal      <= in_valid && !w_legal;
        end
    end

    assign out_valid        = r_valid;
    assign out_rd           = r_rd;
    assign out_result       = r_result;
    assign out_store_data   = r_store_data;
    assign out_link         = r_link;
    assign out_reg_write    = r_reg_write;
    assign out_mem_read     = r_mem_read;
    assign out_mem_write    = r_mem_write;
    assign out_branch_taken = r_branch_taken;
    assign out_jump         = r_jump;
    assign out_illegal      = r_illegal;

endmodule

// File: tb/tb_decode_execute_unit.sv
// tb/tb_decode_execute_unit.sv - self-checking bench for decode_execute_unit
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [31:0] out_link;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch_taken;
    logic        out_jump;
    logic        out_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_execute_unit dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .inst             (inst),
        .pc               (pc),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .out_valid        (out_valid),
        .out_rd           (out_rd),
        .out_result       (out_result),
        .out_store_data   (out_store_data),
        .out_link         (out_link),
        .out_reg_write    (out_reg_write),
        .out_mem_read     (out_mem_read),
        .out_mem_write    (out_mem_write),
        .out_branch_taken (out_branch_taken),
        .out_jump         (out_jump),
        .out_illegal      (out_illegal)
    );

    typedef struct {
        logic        zero_all;
        logic        valid;
        logic        ill;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        bt;
        logic        j;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] st;
        logic [31:0] link;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << bits;
        return v[bits-1] ? (v | m) : (v & ~m);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        int sh;
        sh = int'(y % 32);
        case (f3)
            3'd0: r = alt ? x - y : x + y;
            3'd1: r = x << sh;
            3'd4: r = x ^ y;
            3'd5: begin
                r = x >> sh;
                if (alt && x[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = x | y;
            3'd7: r = x & y;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic r, input logic v, input logic [31:0] in,
                                   input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic ok;
        logic [2:0] f3;
        logic [6:0] f7;
        e = '{zero_all: 1'b0, valid: 1'b0, ill: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0,
              bt: 1'b0, j: 1'b0, rd: 5'd0, res: 32'd0, st: 32'd0, link: 32'd0};
        if (r) begin
            e.zero_all = 1'b1;
            return e;
        end
        if (!v) return e;
        e.valid = 1'b1;
        e.rd    = in[11:7];
        f3      = in[14:12];
        f7      = in[31:25];
        ok      = 1'b0;
        case (in[6:0])
            7'b0110011: begin
                ok = (f3 != 2 && f3 != 3) && (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                e.res = alu_ref(f3, f7[5], a, b);
                e.rw = 1'b1;
            end
            7'b0010011: begin
                ok = (f3 != 2 && f3 != 3);
                e.res = alu_ref(f3, (f3 == 5) && f7[5], a, sx({20'd0, in[31:20]}, 12));
                e.rw = 1'b1;
            end
            7'b0000011: begin
                ok = (f3 == 2);
                e.res = a + sx({20'd0, in[31:20]}, 12);
                e.rw = 1'b1;
                e.mr = 1'b1;
            end
            7'b0100011: begin
                ok = (f3 == 2);
                e.res = a + sx({20'd0, in[31:25], in[11:7]}, 12);
                e.mw = 1'b1;
                e.st = b;
            end
            7'b1100011: begin
                ok = (f3 == 0);
                e.res = p + sx({19'd0, in[31], in[7], in[30:25], in[11:8], 1'b0}, 13);
                e.bt = (a == b);
            end
            7'b1101111: begin
                ok = 1'b1;
                e.res = p + sx({11'd0, in[31], in[19:12], in[20], in[30:21], 1'b0}, 21);
                e.link = p + 4;
                e.rw = 1'b1;
                e.j = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.ill = 1'b1;
            e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.bt = 1'b0; e.j = 1'b0;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    exp_t exp_q;
    logic have_exp = 1'b0;

    always @(posedge clk) begin
        exp_q    <= model(rst, in_valid, inst, pc, rs1_data, rs2_data);
        have_exp <= 1'b1;
    end

    always @(negedge clk) begin
        if (have_exp) begin
            chk("m_valid", {31'd0, out_valid},        {31'd0, exp_q.valid});
            chk("m_ill",   {31'd0, out_illegal},      {31'd0, exp_q.ill});
            chk("m_rw",    {31'd0, out_reg_write},    {31'd0, exp_q.rw});
            chk("m_mr",    {31'd0, out_mem_read},     {31'd0, exp_q.mr});
            chk("m_mw",    {31'd0, out_mem_write},    {31'd0, exp_q.mw});
            chk("m_bt",    {31'd0, out_branch_taken}, {31'd0, exp_q.bt});
            chk("m_j",     {31'd0, out_jump},         {31'd0, exp_q.j});
            if (exp_q.zero_all) begin
                chk("m_rst_rd",   {27'd0, out_rd}, 32'd0);
                chk("m_rst_res",  out_result,      32'd0);
                chk("m_rst_st",   out_store_data,  32'd0);
                chk("m_rst_link", out_link,        32'd0);
            end else if (exp_q.valid) begin
                chk("m_rd", {27'd0, out_rd}, {27'd0, exp_q.rd});
                if (!exp_q.ill) chk("m_res", out_result, exp_q.res);
                if (exp_q.mw)   chk("m_st", out_store_data, exp_q.st);
                if (exp_q.j)    chk("m_link", out_link, exp_q.link);
            end
        end
    end

    task automatic apply(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v; inst = i; pc = p; rs1_data = a; rs2_data = b;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] pool [12] = '{
        32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h00000013, 32'h0020A423,
        32'h00208863, 32'h008000EF, 32'h4020D1B3, 32'h4040D193, 32'h0020A283,
        32'h0020A1B3, 32'h0040F313
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; inst = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply(1, 32'h002081B3, 32'h0, 5, 7);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_res", out_result, 32'd12);
        chk("add_rw", {31'd0, out_reg_write}, 32'd1);
        chk("add_rs1a", {27'd0, rs1_addr}, 32'd1);
        chk("add_rs2a", {27'd0, rs2_addr}, 32'd2);

        apply(1, 32'h402081B3, 32'h4, 5, 7);
        chk("sub_res", out_result, 32'hFFFF_FFFE);
        apply(1, 32'hFFF00293, 32'h8, 0, 0);
        chk("addi_res", out_result, 32'hFFFF_FFFF);
        chk("addi_rd", {27'd0, out_rd}, 32'd5);
        apply(1, 32'h00000013, 32'hC, 0, 0);
        chk("nop_rw", {31'd0, out_reg_write}, 32'd0);

        apply(1, 32'h0020A423, 32'h10, 32'h100, 32'hAB);
        chk("sw_res", out_result, 32'h108);
        chk("sw_st", out_store_data, 32'hAB);
        chk("sw_mw", {31'd0, out_mem_write}, 32'd1);
        chk("sw_rw", {31'd0, out_reg_write}, 32'd0);

        apply(1, 32'h00208863, 32'h40, 9, 9);
        chk("beq_t", {31'd0, out_branch_taken}, 32'd1);
        chk("beq_res", out_result, 32'h50);
        apply(1, 32'h00208863, 32'h40, 9, 8);
        chk("beq_nt", {31'd0, out_branch_taken}, 32'd0);

        apply(1, 32'h008000EF, 32'h20, 0, 0);
        chk("jal_j", {31'd0, out_jump}, 32'd1);
        chk("jal_res", out_result, 32'h28);
        chk("jal_link", out_link, 32'h24);
        chk("jal_rd", {27'd0, out_rd}, 32'd1);
        chk("jal_rw", {31'd0, out_reg_write}, 32'd1);

        apply(1, 32'h4020D1B3, 32'h0, 32'h8000_0000, 4);
        chk("sra_res", out_result, 32'hF800_0000);
        apply(1, 32'h4040D193, 32'h0, 32'h8000_0000, 0);
        chk("srai_res", out_result, 32'hF800_0000);
        apply(1, 32'h0020A1B3, 32'h0, 1, 2);
        chk("slt_ill", {31'd0, out_illegal}, 32'd1);
        chk("slt_valid", {31'd0, out_valid}, 32'd1);
        chk("slt_rw", {31'd0, out_reg_write}, 32'd0);
        apply(0, 32'h002081B3, 32'h0, 5, 7);
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_rw", {31'd0, out_reg_write}, 32'd0);

        apply(1, 32'h4020C1B3, 32'h0, 3, 5);
        apply(1, 32'h00209863, 32'h0, 3, 3);
        apply(1, 32'h0020B283, 32'h0, 3, 3);
        apply(1, 32'h0000007F, 32'h0, 3, 3);
        apply(1, 32'h0020A283, 32'h0, 32'h200, 0);
        chk("lw_mr", {31'd0, out_mem_read}, 32'd1);
        chk("lw_res", out_result, 32'h202);

        @(negedge clk);
        rst = 1'b1;
        apply(1, 32'h002081B3, 32'h0, 5, 7);
        chk("rstv_valid", {31'd0, out_valid}, 32'd0);
        chk("rstv_res", out_result, 32'd0);
        chk("rstv_rw", {31'd0, out_reg_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            apply(($urandom_range(0, 7) != 0), pool[$urandom_range(0, 11)],
                  $urandom & 32'hFFFF_FFFC, a, b);
        end

        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_execute_unit.md
Name: decode_execute_unit

Overview:
- Combined instruction decoder, control unit and ALU for the 5-stage RV32I-subset pipeline.
- Accepts the 32-bit instruction from the IF/ID register, together with its PC and the register-file read data.
- Produces registered control signals and execute results, which become the EX/MEM register contents.
- Supports R-type ALU, I-type ALU, LW, SW, BEQ and JAL.

Parameters:
- XLEN, 32, datapath width. Fixed at 32; the only legal value.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  inst/pc/rs data are valid this cycle.
- inst  in  32  instruction word.
- pc  in  32  address of inst.
- rs1_data  in  32  register-file data for rs1_addr.
- rs2_data  in  32  register-file data for rs2_addr.
- rs1_addr  out  5  inst[19:15]; combinational.
- rs2_addr  out  5  inst[24:20]; combinational.
- out_valid  out  1  registered outputs hold a valid instruction.
- out_rd  out  5  destination register.
- out_result  out  32  ALU result: arithmetic value, memory address, or branch/jump target.
- out_store_data  out  32  rs2_data captured for SW.
- out_link  out  32  pc+4, the JAL write-back value.
- out_reg_write  out  1  write-back enable.
- out_mem_read  out  1  LW.
- out_mem_write  out  1  SW.
- out_branch_taken  out  1  BEQ and rs1_data==rs2_data.
- out_jump  out  1  JAL.
- out_illegal  out  1  unsupported opcode or funct encoding.

Behaviour:
- Reset: every registered output is 0 on the first rising edge with rst=1. rst has priority over in_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. No stall or backpressure.
- in_valid=0 (bubble): after the edge out_valid=0 and all enables/flags are 0. Data outputs may hold any value.

Immediates, all sign-extended to 32 bits:
- I: inst[31:20].
- S: {inst[31:25],inst[11:7]}.
- B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
- J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.

Operand selection:
- op1 = rs1_data for opcodes 0110011, 0010011, 0000011 and 0100011.
- op1 = pc for opcodes 1100011 and 1101111.
- op2 = rs2_data for R-type; I-imm for I-type and LW; S-imm for SW; B-imm for BEQ; J-imm for JAL.

alusel codes (3 bits): 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- funct3 000: ADD; SUB only in R-type when funct7[5]=1.
- funct3 111: AND. 110: OR. 100: XOR. 001: SLL.
- funct3 101: SRL, or SRA when funct7[5]=1.
- Shift amount is op2[4:0]. For I-type shifts op2[4:0] is inst[24:20].
- LW, SW, BEQ and JAL force ADD.

Legality:
- Legal: the six opcodes listed, with funct3 010 for LW/SW and funct3 000 for BEQ.
- R-type funct7 must be 0000000, or 0100000 only with funct3 000/101.
- funct3 010/011 (SLT/SLTU) in ALU ops is illegal.
- Illegal instruction: out_illegal=1, out_valid=1, all other enables 0.

Control:
- out_reg_write = 1 for R-type, I-type, LW and JAL, but forced to 0 when rd = 0. NOP 0x00000013 therefore writes nothing.
- out_rd = inst[11:7], captured for every instruction.
- Arithmetic wraps modulo 2^32. Overflow is ignored.

Decomposition:
- Shared package (e.g. rv_pkg) holds:
  - opcode constants: OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_JAL=1101111;
  - the alusel encoding as a 3-bit enum.
- One natural sub-module, rv_alu: purely combinational, inputs op1/op2/alusel, output result.
- Decode, immediate generation and control stay in the top module, with the output register stage.

Test Plan:
1. Reset and ADD: hold rst=1 for 2 cycles, all outputs 0. Then inst=0x002081B3 (add x3,x1,x2) with rs1_data=5, rs2_data=7. After 1 edge: out_valid=1, out_rd=3, out_result=12, out_reg_write=1, rs1_addr=1, rs2_addr=2.
2. SUB and ADDI to x0:
   - 0x402081B3 with 5, 7 gives out_result=0xFFFFFFFE.
   - 0xFFF00293 (addi x5,x0,-1) with rs1_data=0 gives out_result=0xFFFFFFFF, out_rd=5.
   - 0x00000013 gives out_reg_write=0.
3. SW: 0x0020A423 (sw x2,8(x1)) with rs1_data=0x100, rs2_data=0xAB gives out_result=0x108, out_store_data=0xAB, out_mem_write=1, out_reg_write=0.
4. BEQ: 0x00208863 at pc=0x40. With rs1_data=rs2_data=9: out_branch_taken=1, out_result=0x50. With rs2_data=8: out_branch_taken=0.
5. JAL: 0x008000EF at pc=0x20 gives out_jump=1, out_result=0x28, out_link=0x24, out_rd=1, out_reg_write=1.
6. Edge cases:
   - SRA with rs1_data=0x80000000, shift 4, gives 0xF8000000.
   - SLT opcode (funct3 010, R-type) gives out_illegal=1.
   - in_valid=0 gives out_valid=0.
   - rst asserted together with a valid ADD: outputs all 0 on that edge.
